// File: rtl/mult_sched.sv
// Shares one pipelined multiplier among NUM_REQ requesters: round-robin issue of
// one op at a time, completion held on a valid/ready port, flush drains in-flight work.
module mult_sched #(
  parameter int NUM_REQ   = 4,
  parameter int NUM_STAGE = 4,
  parameter int TAG_W     = 6,
  parameter int XLEN      = 32
) (
  input  logic                           clock_i,
  input  logic                           reset_ni,
  input  logic [NUM_REQ-1:0]             req_valid_i,
  input  logic [NUM_REQ-1:0][XLEN-1:0]   req_mcand_i,
  input  logic [NUM_REQ-1:0][XLEN-1:0]   req_mplier_i,
  input  logic [NUM_REQ-1:0][1:0]        req_func_i,
  input  logic [NUM_REQ-1:0][TAG_W-1:0]  req_tag_i,
  output logic [NUM_REQ-1:0]             grant_o,
  input  logic                           flush_i,
  output logic                           mult_start_o,
  output logic [XLEN-1:0]                mult_mcand_o,
  output logic [XLEN-1:0]                mult_mplier_o,
  output logic [1:0]                     mult_sign_o,
  output logic [1:0]                     mult_func_o,
  input  logic                           mult_done_i,
  input  logic [XLEN-1:0]                mult_product_i,
  output logic                           cpl_valid_o,
  output logic [XLEN-1:0]                cpl_value_o,
  output logic [TAG_W-1:0]               cpl_tag_o,
  input  logic                           cpl_ready_i,
  output logic                           busy_o
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, HOLD, DRAIN} state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [TAG_W-1:0]  op_tag_q, op_tag_d;
  logic              cpl_valid_q, cpl_valid_d;
  logic [XLEN-1:0]   cpl_value_q, cpl_value_d;
  logic [TAG_W-1:0]  cpl_tag_q, cpl_tag_d;

  logic              can_grant, found, gnt_any;
  logic [PW-1:0]     sel;
  int                idx;

  // Reset gates the grant so nothing issues combinationally while reset is held.
  assign can_grant = reset_ni && !flush_i &&
                     ((state_q == IDLE) || (state_q == HOLD && cpl_ready_i));

  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr_q) + k) % NUM_REQ;
      if (!found && req_valid_i[idx]) begin
        found = 1'b1;
        sel   = PW'(idx);
      end
    end
  end

  assign gnt_any = can_grant && found;

  always_comb begin
    grant_o       = '0;
    mult_mcand_o  = '0;
    mult_mplier_o = '0;
    mult_func_o   = '0;
    mult_sign_o   = '0;
    if (gnt_any) begin
      grant_o[sel]  = 1'b1;
      mult_mcand_o  = req_mcand_i[sel];
      mult_mplier_o = req_mplier_i[sel];
      mult_func_o   = req_func_i[sel];
      case (req_func_i[sel])
        2'b00, 2'b01: mult_sign_o = 2'b11;
        2'b10:        mult_sign_o = 2'b01;
        default:      mult_sign_o = 2'b00;
      endcase
    end
  end

  assign mult_start_o = gnt_any;

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    op_tag_d    = op_tag_q;
    cpl_valid_d = cpl_valid_q;
    cpl_value_d = cpl_value_q;
    cpl_tag_d   = cpl_tag_q;
    if (gnt_any) begin
      rr_ptr_d = (sel == PW'(NUM_REQ-1)) ? '0 : sel + 1'b1;
      op_tag_d = req_tag_i[sel];
    end
    case (state_q)
      IDLE: if (gnt_any) state_d = BUSY;
      BUSY: begin
        // A flush coinciding with done still discards the result.
        if (flush_i) state_d = DRAIN;
        else if (mult_done_i) begin
          state_d     = HOLD;
          cpl_valid_d = 1'b1;
          cpl_value_d = mult_product_i;
          cpl_tag_d   = op_tag_q;
        end
      end
      HOLD: begin
        if (flush_i) begin
          state_d     = IDLE;
          cpl_valid_d = 1'b0;
        end else if (cpl_ready_i) begin
          cpl_valid_d = 1'b0;
          state_d     = gnt_any ? BUSY : IDLE;
        end
      end
      DRAIN: if (mult_done_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      op_tag_q    <= '0;
      cpl_valid_q <= 1'b0;
      cpl_value_q <= '0;
      cpl_tag_q   <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      op_tag_q    <= op_tag_d;
      cpl_valid_q <= cpl_valid_d;
      cpl_value_q <= cpl_value_d;
      cpl_tag_q   <= cpl_tag_d;
    end
  end

  assign cpl_valid_o = cpl_valid_q;
  assign cpl_value_o = cpl_value_q;
  assign cpl_tag_o   = cpl_tag_q;
  assign busy_o      = (state_q != IDLE);
endmodule

// File: tb/tb_mult_sched.sv
// Directed bench for mult_sched with a behavioural NUM_STAGE-deep multiplier attached.
module tb_mult_sched;
  localparam int NR = 4, NS = 4, TW = 6, XL = 32;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [NR-1:0]          req_valid;
  logic [NR-1:0][XL-1:0]  req_mcand, req_mplier;
  logic [NR-1:0][1:0]     req_func;
  logic [NR-1:0][TW-1:0]  req_tag;
  logic [NR-1:0]          grant;
  logic                   flush, mult_start, mult_done, cpl_valid, cpl_ready, busy;
  logic [XL-1:0]          mult_mcand, mult_mplier, mult_product, cpl_value;
  logic [1:0]             mult_sign, mult_func;
  logic [TW-1:0]          cpl_tag;

  int npass = 0, ntotal = 0;

  always #5 clk = ~clk;

  mult_sched #(.NUM_REQ(NR), .NUM_STAGE(NS), .TAG_W(TW), .XLEN(XL)) dut (
    .clock_i(clk), .reset_ni(rst_n),
    .req_valid_i(req_valid), .req_mcand_i(req_mcand), .req_mplier_i(req_mplier),
    .req_func_i(req_func), .req_tag_i(req_tag), .grant_o(grant), .flush_i(flush),
    .mult_start_o(mult_start), .mult_mcand_o(mult_mcand), .mult_mplier_o(mult_mplier),
    .mult_sign_o(mult_sign), .mult_func_o(mult_func), .mult_done_i(mult_done),
    .mult_product_i(mult_product), .cpl_valid_o(cpl_valid), .cpl_value_o(cpl_value),
    .cpl_tag_o(cpl_tag), .cpl_ready_i(cpl_ready), .busy_o(busy)
  );

  // Multiplier stand-in: latches on start, sign-extends per mult_sign, selects per func.
  logic [NS:1]   dsr;
  logic [XL-1:0] psr [1:NS];
  logic [63:0]   ea, eb, full;
  assign ea   = mult_sign[0] ? {{32{mult_mcand[31]}}, mult_mcand}   : {32'b0, mult_mcand};
  assign eb   = mult_sign[1] ? {{32{mult_mplier[31]}}, mult_mplier} : {32'b0, mult_mplier};
  assign full = ea * eb;
  assign mult_done    = dsr[NS];
  assign mult_product = psr[NS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dsr <= '0;
      for (int i = 1; i <= NS; i++) psr[i] <= '0;
    end else begin
      dsr    <= {dsr[NS-1:1], mult_start};
      psr[1] <= (mult_func == 2'b00) ? full[31:0] : full[63:32];
      for (int i = 2; i <= NS; i++) psr[i] <= psr[i-1];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_valid = '0; req_mcand = '0; req_mplier = '0;
    req_func = '0; req_tag = '0; flush = 1'b0; cpl_ready = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] f, input logic [5:0] t);
    req_mcand[i] = a; req_mplier[i] = b; req_func[i] = f; req_tag[i] = t;
    req_valid[i] = 1'b1;
  endtask

  int          gcyc [5];
  logic [3:0]  gval [5];
  int          n;

  initial begin
    // Reset state
    do_reset();
    rst_n = 1'b0; #1;
    chk("rst_regs", {cpl_valid, cpl_value, cpl_tag, busy}, 64'd0);
    chk("rst_issue", {grant, mult_start, mult_sign, mult_func}, 64'd0);
    chk("rst_ops", {mult_mcand, mult_mplier}, 64'd0);
    rst_n = 1'b1;

    // Single op: requester 2, MUL 7 x -3, tag 5
    do_reset();
    set_req(2, 32'd7, 32'hFFFF_FFFD, 2'b00, 6'd5); #1;
    chk("single_grant", grant, 4'b0100);
    chk("single_sign", mult_sign, 2'b11);
    chk("single_ops", {mult_start, mult_mcand, mult_mplier}, {1'b1, 32'd7, 32'hFFFF_FFFD});
    tick(); req_valid = '0; #1;
    chk("single_busy_nogrant", {busy, grant}, {1'b1, 4'b0});
    for (int c = 2; c <= 4; c++) begin
      tick(); #1;
      chk("single_no_cpl_early", cpl_valid, 1'b0);
    end
    chk("single_done_T4", mult_done, 1'b1);
    tick(); #1;
    chk("single_cpl", {cpl_valid, cpl_value, cpl_tag}, {1'b1, 32'hFFFF_FFEB, 6'd5});
    cpl_ready = 1'b1;
    tick(); cpl_ready = 1'b0; #1;
    chk("single_idle", {cpl_valid, busy}, 2'b00);

    // Round robin with all requesters valid and ready high
    do_reset();
    for (int i = 0; i < NR; i++) set_req(i, 32'(i + 1), 32'd3, 2'b00, 6'(i));
    cpl_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 40 && n < 5; c++) begin
      #1;
      if (grant != '0) begin gcyc[n] = c; gval[n] = grant; n++; end
      tick();
    end
    req_valid = '0;
    chk("rr_count", n, 5);
    chk("rr_g0", gval[0], 4'b0001);
    chk("rr_g1", gval[1], 4'b0010);
    chk("rr_g2", gval[2], 4'b0100);
    chk("rr_g3", gval[3], 4'b1000);
    chk("rr_g4", gval[4], 4'b0001);
    for (int k = 1; k < 5; k++) chk("rr_spacing", gcyc[k] - gcyc[k-1], 5);

    // Backpressure: result held 10 cycles while requester 1 waits
    do_reset();
    set_req(0, 32'd3, 32'd4, 2'b00, 6'd9); #1;
    chk("bp_grant0", grant, 4'b0001);
    tick(); req_valid = '0;
    for (int c = 0; c < 4; c++) tick();
    set_req(1, 32'd5, 32'd6, 2'b00, 6'd7);
    for (int c = 0; c < 10; c++) begin
      #1;
      chk("bp_hold", {cpl_valid, cpl_value, cpl_tag, grant}, {1'b1, 32'd12, 6'd9, 4'b0});
      tick();
    end
    cpl_ready = 1'b1; #1;
    chk("bp_release_grant", grant, 4'b0010);
    tick(); req_valid = '0; #1;
    chk("bp_after_release", {cpl_valid, busy}, 2'b01);
    for (int c = 0; c < 4; c++) tick();
    #1;
    chk("bp_second_cpl", {cpl_valid, cpl_value, cpl_tag}, {1'b1, 32'd30, 6'd7});

    // Sign mapping: MULHSU then MULHU with 0xFFFFFFFF x 2
    do_reset();
    set_req(0, 32'hFFFF_FFFF, 32'd2, 2'b10, 6'd1); #1;
    chk("mulhsu_sign", {mult_sign, mult_func}, {2'b01, 2'b10});
    tick(); req_valid = '0;
    for (int c = 0; c < 4; c++) tick();
    #1;
    chk("mulhsu_value", {cpl_valid, cpl_value}, {1'b1, 32'hFFFF_FFFF});
    cpl_ready = 1'b1; tick(); cpl_ready = 1'b0;
    set_req(1, 32'hFFFF_FFFF, 32'd2, 2'b11, 6'd2); #1;
    chk("mulhu_sign", {grant, mult_sign, mult_func}, {4'b0010, 2'b00, 2'b11});
    tick(); req_valid = '0;
    for (int c = 0; c < 4; c++) tick();
    #1;
    chk("mulhu_value", {cpl_valid, cpl_value, cpl_tag}, {1'b1, 32'd1, 6'd2});

    // Flush in BUSY at T+2, pending request granted at T+5
    do_reset();
    set_req(0, 32'd2, 32'd2, 2'b00, 6'd3);
    tick(); req_valid = '0;            // T+1
    tick(); flush = 1'b1;              // T+2
    tick(); flush = 1'b0;              // T+3
    set_req(1, 32'd9, 32'd9, 2'b00, 6'd4); #1;
    chk("flush_drain_T3", {busy, grant, cpl_valid}, {1'b1, 4'b0, 1'b0});
    tick(); #1;                        // T+4
    chk("flush_drain_T4", {busy, grant, cpl_valid, mult_done}, {1'b1, 4'b0, 1'b0, 1'b1});
    tick(); #1;                        // T+5
    chk("flush_idle_T5", {busy, grant, cpl_valid}, {1'b0, 4'b0010, 1'b0});

    // Async reset in the middle of HOLD
    do_reset();
    set_req(2, 32'd1, 32'd1, 2'b00, 6'd8);
    tick(); req_valid = '0;
    for (int c = 0; c < 4; c++) tick();
    req_valid = 4'b1111; #1;
    chk("ar_in_hold", {cpl_valid, busy, grant}, {1'b1, 1'b1, 4'b0});
    rst_n = 1'b0; #1;
    chk("ar_immediate", {cpl_valid, busy, grant}, {1'b0, 1'b0, 4'b0});
    rst_n = 1'b1; #1;
    chk("ar_first_grant", grant, 4'b0001);
    req_valid = '0;
    tick();

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end
endmodule
